bitwave_tile_sequencer: RTL and testbench

//  Layer-level sequencer for the BitWave core. Walks a GEMM layer as N output tiles x K reduction tiles.
//  Per tile: streams weight/activation rows from SRAM into the dispatcher buffers, starts the PE array

---
 rtl/bitwave_pkg.sv | 17 +
 rtl/bitwave_addr_gen.sv | 52 +++++
 rtl/bitwave_tile_sequencer.sv | 133 +++++++++++++
 tb/tb_bitwave_tile_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwave_pkg.sv
// Shared types and constants for the BitWave layer sequencer.
package bitwave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DRAIN   = 3'd2,
    COMPUTE = 3'd3,
    WRITE   = 3'd4,
    FIN     = 3'd5
  } state_e;

  localparam logic [1:0] ACC_CLR = 2'b11;
  localparam logic [1:0] ACC_ON  = 2'b01;
  localparam logic [1:0] ACC_OFF = 2'b00;

endpackage

// File: rtl/bitwave_addr_gen.sv
// Weight/activation read pointers and the one-cycle SRAM-to-buffer write delay line.
module bitwave_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int BUF_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              rewind,
  input  logic              step,
  input  logic [BUF_AW-1:0] row,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] a_addr,
  output logic              buf_wen,
  output logic [BUF_AW-1:0] buf_addr
);

  logic [ADDR_W-1:0] w_ptr_q;
  logic [ADDR_W-1:0] a_ptr_q;
  logic [ADDR_W-1:0] a_base_q;

  // The weight pointer only ever advances; the activation pointer rewinds per output tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q  <= '0;
      a_ptr_q  <= '0;
      a_base_q <= '0;
      buf_wen  <= 1'b0;
      buf_addr <= '0;
    end else begin
      if (init) begin
        w_ptr_q  <= w_base;
        a_ptr_q  <= a_base;
        a_base_q <= a_base;
      end else begin
        if (step) begin
          w_ptr_q <= w_ptr_q + ADDR_W'(1);
          a_ptr_q <= a_ptr_q + ADDR_W'(1);
        end
        if (rewind) a_ptr_q <= a_base_q;
      end
      buf_wen  <= step;
      buf_addr <= step ? row : '0;
    end
  end

  assign w_addr = step ? w_ptr_q : '0;
  assign a_addr = step ? a_ptr_q : '0;

endmodule

// File: rtl/bitwave_tile_sequencer.sv
// Layer sequencer: walks N output tiles x K reduction tiles, loading buffers, running the PE array, writing results.
module bitwave_tile_sequencer
  import bitwave_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BUF_AW    = 6,
  parameter int TILE_ROWS = 8,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_k_tiles,
  input  logic [CNT_W-1:0]  cfg_n_tiles,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_o_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_w_read_address,
  output logic [ADDR_W-1:0] sram_a_read_address,
  output logic              buf_wen,
  output logic [BUF_AW-1:0] buf_write_address,
  output logic              pe_start,
  output logic [1:0]        acc_en,
  input  logic              pe_done,
  output logic              result_we,
  output logic [ADDR_W-1:0] sram_write_address,
  output state_e            dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [BUF_AW-1:0] LAST_ROW = BUF_AW'(TILE_ROWS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, n_q, k_tiles_q, n_tiles_q;
  logic [ADDR_W-1:0] o_base_q;
  logic [BUF_AW-1:0] row_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              error_q;

  logic accept, last_row, last_k, last_n, tile_done, timeout, rewind;

  assign accept    = (state_q == IDLE) && start;
  assign last_row  = (row_q == LAST_ROW);
  assign last_k    = (k_q == k_tiles_q - CNT_W'(1));
  assign last_n    = (n_q == n_tiles_q - CNT_W'(1));
  // A pe_done seen on the COMPUTE entry cycle belongs to the previous tile and is dropped.
  assign tile_done = (state_q == COMPUTE) && (tmr_q != '0) && pe_done;
  assign timeout   = (state_q == COMPUTE) && !tile_done && (tmr_q == TMR_W'(TIMEOUT - 1));
  assign rewind    = (state_q == WRITE) && !last_n;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (cfg_k_tiles == '0 || cfg_n_tiles == '0) ? FIN : LOAD;
      LOAD:    if (last_row) state_d = DRAIN;
      DRAIN:   state_d = COMPUTE;
      COMPUTE: begin
        if (tile_done)    state_d = last_k ? WRITE : LOAD;
        else if (timeout) state_d = FIN;
      end
      WRITE:   state_d = last_n ? FIN : LOAD;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      k_tiles_q <= '0;
      n_tiles_q <= '0;
      o_base_q  <= '0;
      row_q     <= '0;
      tmr_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_tiles_q <= cfg_k_tiles;
        n_tiles_q <= cfg_n_tiles;
        o_base_q  <= cfg_o_base;
        k_q       <= '0;
        n_q       <= '0;
        row_q     <= '0;
        error_q   <= 1'b0;
      end
      if (state_q == LOAD) row_q <= last_row ? '0 : row_q + BUF_AW'(1);
      tmr_q <= (state_q == COMPUTE) ? tmr_q + TMR_W'(1) : '0;
      if (tile_done && !last_k) k_q <= k_q + CNT_W'(1);
      if (timeout) error_q <= 1'b1;
      if (rewind) begin
        n_q <= n_q + CNT_W'(1);
        k_q <= '0;
      end
    end
  end

  bitwave_addr_gen #(
    .ADDR_W(ADDR_W),
    .BUF_AW(BUF_AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (accept),
    .rewind   (rewind),
    .step     (state_q == LOAD),
    .row      (row_q),
    .w_base   (cfg_w_base),
    .a_base   (cfg_a_base),
    .w_addr   (sram_w_read_address),
    .a_addr   (sram_a_read_address),
    .buf_wen  (buf_wen),
    .buf_addr (buf_write_address)
  );

  assign busy               = (state_q inside {LOAD, DRAIN, COMPUTE, WRITE});
  assign done               = (state_q == FIN);
  assign error              = error_q;
  assign sram_en            = (state_q == LOAD);
  assign pe_start           = (state_q == COMPUTE) && (tmr_q == '0);
  assign acc_en             = (state_q != COMPUTE) ? ACC_OFF : ((k_q == '0) ? ACC_CLR : ACC_ON);
  assign result_we          = (state_q == WRITE);
  assign sram_write_address = (state_q == WRITE) ? o_base_q + ADDR_W'(n_q) : '0;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_bitwave_tile_sequencer.sv
// Directed bench for bitwave_tile_sequencer with a queue-based scoreboard and a PE responder model.
module tb_bitwave_tile_sequencer;
  import bitwave_pkg::*;

  localparam int ADDR_W = 16, BUF_AW = 6, TILE_ROWS = 8, CNT_W = 8, TIMEOUT = 4096;
  localparam int PE_LAT = 5;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, pe_done = 1'b0;
  logic [CNT_W-1:0]  cfg_k_tiles = '0, cfg_n_tiles = '0;
  logic [ADDR_W-1:0] cfg_w_base = '0, cfg_a_base = '0, cfg_o_base = '0;
  logic              busy, done, error, sram_en, buf_wen, pe_start, result_we;
  logic [ADDR_W-1:0] sram_w_read_address, sram_a_read_address, sram_write_address;
  logic [BUF_AW-1:0] buf_write_address;
  logic [1:0]        acc_en;
  state_e            dbg_state;

  bitwave_tile_sequencer #(
    .ADDR_W(ADDR_W), .BUF_AW(BUF_AW), .TILE_ROWS(TILE_ROWS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_o_base(cfg_o_base),
    .busy(busy), .done(done), .error(error),
    .sram_en(sram_en), .sram_w_read_address(sram_w_read_address),
    .sram_a_read_address(sram_a_read_address),
    .buf_wen(buf_wen), .buf_write_address(buf_write_address),
    .pe_start(pe_start), .acc_en(acc_en), .pe_done(pe_done),
    .result_we(result_we), .sram_write_address(sram_write_address),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int n_vec = 0, n_err = 0;
  logic [31:0]       rd_q[$];
  logic [BUF_AW-1:0] wr_q[$];
  logic [15:0]       pe_q[$];
  logic [15:0]       res_q[$];
  logic [0:0]        done_q[$];
  bit mon_en = 1'b1;
  bit pe_hang = 1'b0, pe_stale = 1'b0, pe_noise = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  function automatic logic [63:0] out_vec();
    return {busy, done, error, sram_en, sram_w_read_address, sram_a_read_address, buf_wen,
            buf_write_address, pe_start, acc_en, result_we, sram_write_address};
  endfunction

  // Expected traffic for one run, straight from the layer walk definition
  task automatic push_run(input int k, input int n, input logic [15:0] wb, input logic [15:0] ab,
                          input logic [15:0] ob, input bit hang);
    logic [15:0] w, a;
    w = wb;
    if (k == 0 || n == 0) begin
      done_q.push_back(1'b0);
      return;
    end
    for (int ni = 0; ni < n; ni++) begin
      a = ab;
      for (int ki = 0; ki < k; ki++) begin
        for (int r = 0; r < TILE_ROWS; r++) begin
          rd_q.push_back({w, a});
          wr_q.push_back(BUF_AW'(r));
          w = w + 16'd1;
          a = a + 16'd1;
        end
        pe_q.push_back({(ki == 0) ? 2'b11 : 2'b01, hang ? 14'(TIMEOUT) : 14'(PE_LAT + 1)});
        if (hang) begin
          done_q.push_back(1'b1);
          return;
        end
      end
      res_q.push_back(16'(ob + 16'(ni)));
    end
    done_q.push_back(1'b0);
  endtask

  // PE array model: pe_done PE_LAT cycles after pe_start, with optional stale/out-of-state pulses
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      pe_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) pe_done = 1'b1;
      end
      if (pe_start && !pe_hang) begin
        cnt = PE_LAT;
        if (pe_stale) pe_done = 1'b1;
      end
      if (pe_noise && sram_en) pe_done = 1'b1;
    end
  end

  // Monitor
  bit in_run = 1'b0, acc_bad = 1'b0, prev_en = 1'b0;
  int run_len = 0, exp_len = 0;
  logic [1:0] cur_acc = 2'b00;
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sram_en) begin
          if (rd_q.size() == 0) miss("rd_extra");
          else chk("rd_addr", {sram_w_read_address, sram_a_read_address}, rd_q.pop_front());
        end
        if (buf_wen) begin
          chk("wen_lag", prev_en, 1'b1);
          if (wr_q.size() == 0) miss("wr_extra");
          else chk("buf_row", buf_write_address, wr_q.pop_front());
        end
        if (pe_start) begin
          if (pe_q.size() == 0) miss("pe_extra");
          else begin
            e = pe_q.pop_front();
            chk("acc_en", acc_en, e[15:14]);
            cur_acc = acc_en;
            exp_len = int'(e[13:0]);
            in_run = 1'b1;
            run_len = 0;
            acc_bad = 1'b0;
          end
        end
        if (in_run) begin
          if (acc_en != 2'b00) begin
            run_len++;
            if (acc_en != cur_acc) acc_bad = 1'b1;
          end else begin
            chk("compute_len", run_len, exp_len);
            chk("acc_hold", acc_bad, 1'b0);
            in_run = 1'b0;
          end
        end
        if (result_we) begin
          if (res_q.size() == 0) miss("res_extra");
          else chk("res_addr", sram_write_address, res_q.pop_front());
        end
        if (done) begin
          if (done_q.size() == 0) miss("done_extra");
          else chk("done_err", error, done_q.pop_front());
        end
      end else begin
        in_run = 1'b0;
      end
      prev_en = sram_en;
    end
  end

  // Driver tasks
  task automatic pulse_start(input int k, input int n, input logic [15:0] wb, input logic [15:0] ab,
                             input logic [15:0] ob);
    @(negedge clk);
    cfg_k_tiles = CNT_W'(k);
    cfg_n_tiles = CNT_W'(n);
    cfg_w_base  = wb;
    cfg_a_base  = ab;
    cfg_o_base  = ob;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 6000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 6000 cycles");
    end
    @(negedge clk);
  endtask

  task automatic drain_check();
    @(negedge clk);
    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("pe_left", pe_q.size() + int'(in_run), 0);
    chk("res_left", res_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  task automatic run(input int k, input int n, input logic [15:0] wb, input logic [15:0] ab,
                     input logic [15:0] ob, input bit hang, output int lat);
    push_run(k, n, wb, ab, ob, hang);
    pulse_start(k, n, wb, ab, ob);
    chk("busy_on", busy, (k != 0 && n != 0));
    chk("error_clr", error, 1'b0);
    wait_done(lat);
    drain_check();
  endtask

  initial begin
    int lat, cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outs", out_vec(), 64'd0);
    chk("reset_state", dbg_state, IDLE);

    // 1) single tile
    run(1, 1, 16'h0100, 16'h0200, 16'h0300, 1'b0, lat);

    // 2) k=3, n=2 with stale and out-of-state pe_done pulses
    pe_stale = 1'b1;
    pe_noise = 1'b1;
    run(3, 2, 16'h0000, 16'h1000, 16'h2000, 1'b0, lat);
    pe_stale = 1'b0;
    pe_noise = 1'b0;

    // 3) zero tile counts
    run(0, 5, 16'h0010, 16'h0020, 16'h0030, 1'b0, lat);
    chk("zero_k_lat", lat, 1);
    run(2, 0, 16'h0010, 16'h0020, 16'h0030, 1'b0, lat);
    chk("zero_n_lat", lat, 1);

    // 4) PE timeout, sticky error, cleared by next start
    pe_hang = 1'b1;
    run(1, 1, 16'h0500, 16'h0600, 16'h0700, 1'b1, lat);
    pe_hang = 1'b0;
    repeat (2) @(negedge clk);
    chk("error_sticky", error, 1'b1);
    run(1, 1, 16'h0500, 16'h0600, 16'h0700, 1'b0, lat);
    chk("error_after", error, 1'b0);

    // 5) reset mid-LOAD, then ignored starts while busy
    mon_en = 1'b0;
    pulse_start(2, 2, 16'h0800, 16'h0900, 16'h0A00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_outs", out_vec(), 64'd0);
    chk("rst_mid_state", dbg_state, IDLE);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || sram_en || result_we || done) cnt++;
    end
    chk("rst_quiet", cnt, 0);
    mon_en = 1'b1;
    push_run(1, 2, 16'h0040, 16'h0080, 16'h00C0, 1'b0);
    pulse_start(1, 2, 16'h0040, 16'h0080, 16'h00C0);
    repeat (3) begin
      repeat (5) @(negedge clk);
      cfg_k_tiles = CNT_W'($urandom_range(1, 9));
      cfg_n_tiles = CNT_W'($urandom_range(1, 9));
      cfg_w_base  = 16'($urandom_range(0, 16'hFFFF));
      cfg_a_base  = 16'($urandom_range(0, 16'hFFFF));
      cfg_o_base  = 16'($urandom_range(0, 16'hFFFF));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(lat);
    drain_check();
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || sram_en) cnt++;
    end
    chk("no_restart", cnt, 0);

    // 6) address wrap-around
    run(1, 1, 16'hFFFC, 16'hFFFA, 16'hFFFF, 1'b0, lat);
    chk("wrap_error", error, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
